// File: rtl/stereo_sample_fifo.sv
// rtl/stereo_sample_fifo.sv - stereo pair FIFO between the I2S receiver and the DSP chain
// First-word-fall-through; drops new pairs when full and counts the losses.
module stereo_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic [WIDTH-1:0]         left_sample_in,
  input  logic [WIDTH-1:0]         right_sample_in,
  input  logic                     new_sample_in,
  input  logic                     sample_ready_in,
  output logic                     sample_valid_out,
  output logic [WIDTH-1:0]         left_sample_out,
  output logic [WIDTH-1:0]         right_sample_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     overflow_out,
  output logic [15:0]              drop_count_out,
  input  logic                     clear_overflow_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic [15:0]        r_drop_count;

  logic               w_valid;
  logic               w_full;
  logic               w_pop;
  logic               w_push_ok;
  logic               w_drop;
  logic [2*WIDTH-1:0] w_head;

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == FULL_COUNT);
  assign w_pop     = w_valid && sample_ready_in;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = new_sample_in && (!w_full || w_pop);
  assign w_drop    = new_sample_in && w_full && !w_pop;
  assign w_head    = r_mem[r_rd_ptr];

  assign sample_valid_out = w_valid;
  assign left_sample_out  = w_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
  assign right_sample_out = w_valid ? w_head[WIDTH-1:0]       : '0;
  assign count_out        = r_count;
  assign overflow_out     = r_overflow;
  assign drop_count_out   = r_drop_count;

  // Array contents carry no reset; occupancy alone decides what is visible.
  always_ff @(posedge clock_in) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {left_sample_in, right_sample_in};
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as a clear restarts the tally at one.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_overflow_in)             r_drop_count <= 16'd1;
      else if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end else if (clear_overflow_in) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_stereo_sample_fifo.sv
// tb/tb_stereo_sample_fifo.sv - directed bench for stereo_sample_fifo
// Inputs change and outputs are observed 1 ns after each rising edge.
module tb_stereo_sample_fifo;

  logic        clk;
  logic        rst_n;
  logic [15:0] l_in, r_in;
  logic        new_s, ready, clr;
  logic        valid;
  logic [15:0] l_out, r_out;
  logic [4:0]  cnt;
  logic        ovf;
  logic [15:0] drops;

  int n_checks = 0;
  int n_fails  = 0;

  stereo_sample_fifo #(.DEPTH(16), .WIDTH(16)) dut (
    .clock_in          (clk),
    .reset_n_in        (rst_n),
    .left_sample_in    (l_in),
    .right_sample_in   (r_in),
    .new_sample_in     (new_s),
    .sample_ready_in   (ready),
    .sample_valid_out  (valid),
    .left_sample_out   (l_out),
    .right_sample_out  (r_out),
    .count_out         (cnt),
    .overflow_out      (ovf),
    .drop_count_out    (drops),
    .clear_overflow_in (clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pairs(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      new_s = 1'b1;
      l_in  = 16'(base + i);
      r_in  = 16'(-(base + i));
      step();
    end
    new_s = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; new_s = 0; ready = 0; clr = 0; l_in = '0; r_in = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++; if (valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (l_out !== 16'h0 || r_out !== 16'h0) begin n_fails++; $display("FAIL reset_data got %h/%h want 0/0", l_out, r_out); end
    n_checks++; if (cnt !== 5'd0) begin n_fails++; $display("FAIL reset_count got %0d want 0", cnt); end
    n_checks++; if (ovf !== 1'b0 || drops !== 16'd0) begin n_fails++; $display("FAIL reset_overflow got %b/%0d want 0/0", ovf, drops); end
  endtask

  task automatic test_single();
    new_s = 1'b1; l_in = 16'h1234; r_in = 16'hFEDC;
    step();
    new_s = 1'b0; l_in = 16'h5555; r_in = 16'h5555;
    n_checks++; if (valid !== 1'b1) begin n_fails++; $display("FAIL single_valid got %b want 1", valid); end
    n_checks++; if (l_out !== 16'h1234 || r_out !== 16'hFEDC) begin n_fails++; $display("FAIL single_data got %h/%h want 1234/fedc", l_out, r_out); end
    n_checks++; if (cnt !== 5'd1) begin n_fails++; $display("FAIL single_count got %0d want 1", cnt); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    n_checks++; if (valid !== 1'b0 || l_out !== 16'h0 || r_out !== 16'h0) begin n_fails++; $display("FAIL single_pop got v=%b %h/%h want v=0 0/0", valid, l_out, r_out); end
    n_checks++; if (cnt !== 5'd0) begin n_fails++; $display("FAIL single_pop_count got %0d want 0", cnt); end
  endtask

  task automatic test_fill_drain();
    push_pairs(16, 0);
    n_checks++; if (cnt !== 5'd16) begin n_fails++; $display("FAIL fill_count got %0d want 16", cnt); end
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (valid !== 1'b1 || l_out !== 16'(i) || r_out !== 16'(-i)) begin
        n_fails++; $display("FAIL drain_%0d got v=%b %h/%h want v=1 %h/%h", i, valid, l_out, r_out, 16'(i), 16'(-i));
      end
      step();
    end
    ready = 1'b0;
    n_checks++; if (valid !== 1'b0 || cnt !== 5'd0) begin n_fails++; $display("FAIL drain_empty got v=%b cnt=%0d want 0/0", valid, cnt); end
    n_checks++; if (ovf !== 1'b0) begin n_fails++; $display("FAIL drain_no_overflow got %b want 0", ovf); end
  endtask

  task automatic test_overflow();
    push_pairs(16, 0);
    push_pairs(3, 100);
    n_checks++; if (ovf !== 1'b1) begin n_fails++; $display("FAIL ovf_flag got %b want 1", ovf); end
    n_checks++; if (drops !== 16'd3) begin n_fails++; $display("FAIL ovf_drops got %0d want 3", drops); end
    n_checks++; if (cnt !== 5'd16) begin n_fails++; $display("FAIL ovf_count got %0d want 16", cnt); end
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (valid !== 1'b1 || l_out !== 16'(i) || r_out !== 16'(-i)) begin
        n_fails++; $display("FAIL ovf_drain_%0d got v=%b %h/%h want v=1 %h/%h", i, valid, l_out, r_out, 16'(i), 16'(-i));
      end
      step();
    end
    ready = 1'b0;
    n_checks++; if (valid !== 1'b0) begin n_fails++; $display("FAIL ovf_no_extra got v=%b l=%h want v=0", valid, l_out); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++; if (ovf !== 1'b0 || drops !== 16'd0) begin n_fails++; $display("FAIL clear got %b/%0d want 0/0", ovf, drops); end
  endtask

  task automatic test_full_push_pop();
    push_pairs(16, 0);
    new_s = 1'b1; ready = 1'b1; l_in = 16'h0AAA; r_in = 16'h0BBB;
    step();
    new_s = 1'b0;
    n_checks++; if (cnt !== 5'd16) begin n_fails++; $display("FAIL fullpp_count got %0d want 16", cnt); end
    n_checks++; if (ovf !== 1'b0 || drops !== 16'd0) begin n_fails++; $display("FAIL fullpp_drop got %b/%0d want 0/0", ovf, drops); end
    for (int i = 1; i < 16; i++) begin
      n_checks++;
      if (valid !== 1'b1 || l_out !== 16'(i)) begin
        n_fails++; $display("FAIL fullpp_drain_%0d got v=%b %h want v=1 %h", i, valid, l_out, 16'(i));
      end
      step();
    end
    n_checks++; if (valid !== 1'b1 || l_out !== 16'h0AAA || r_out !== 16'h0BBB) begin n_fails++; $display("FAIL fullpp_last got v=%b %h/%h want v=1 0aaa/0bbb", valid, l_out, r_out); end
    step();
    ready = 1'b0;
    n_checks++; if (valid !== 1'b0) begin n_fails++; $display("FAIL fullpp_empty got %b want 0", valid); end
  endtask

  task automatic test_wrap();
    logic [15:0] q_l[$];
    logic [15:0] q_r[$];
    int pushed = 0;
    int cyc = 0;
    logic do_push, do_pop;
    while ((pushed < 40 || q_l.size() > 0) && cyc < 500) begin
      n_checks++; if (cnt !== 5'(q_l.size())) begin n_fails++; $display("FAIL wrap_count c%0d got %0d want %0d", cyc, cnt, q_l.size()); end
      if (q_l.size() > 0) begin
        n_checks++;
        if (valid !== 1'b1 || l_out !== q_l[0] || r_out !== q_r[0]) begin
          n_fails++; $display("FAIL wrap_data c%0d got v=%b %h/%h want v=1 %h/%h", cyc, valid, l_out, r_out, q_l[0], q_r[0]);
        end
      end else begin
        n_checks++; if (valid !== 1'b0) begin n_fails++; $display("FAIL wrap_empty c%0d got %b want 0", cyc, valid); end
      end
      do_push = (pushed < 40) && (q_l.size() < 15) && ($urandom_range(0, 1) == 1);
      ready   = ($urandom_range(0, 2) != 0);
      new_s   = do_push;
      l_in    = 16'h5000 + 16'(pushed);
      r_in    = ~(16'h5000 + 16'(pushed));
      do_pop  = (q_l.size() > 0) && ready;
      step();
      if (do_pop) begin void'(q_l.pop_front()); void'(q_r.pop_front()); end
      if (do_push) begin q_l.push_back(l_in); q_r.push_back(r_in); pushed++; end
      cyc++;
    end
    new_s = 1'b0; ready = 1'b0;
    n_checks++; if (cyc >= 500) begin n_fails++; $display("FAIL wrap_timeout got %0d cycles want <500", cyc); end
  endtask

  task automatic test_clear_vs_drop();
    push_pairs(16, 0);
    push_pairs(5, 200);
    n_checks++; if (drops !== 16'd5) begin n_fails++; $display("FAIL cvd_pre got %0d want 5", drops); end
    clr = 1'b1; new_s = 1'b1; l_in = 16'h7777; r_in = 16'h7777;
    step();
    clr = 1'b0; new_s = 1'b0;
    n_checks++; if (ovf !== 1'b1 || drops !== 16'd1) begin n_fails++; $display("FAIL cvd got %b/%0d want 1/1", ovf, drops); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0 || l_out !== 16'h0 || r_out !== 16'h0) begin n_fails++; $display("FAIL async_rst_data got v=%b %h/%h want 0", valid, l_out, r_out); end
    n_checks++; if (cnt !== 5'd0 || ovf !== 1'b0 || drops !== 16'd0) begin n_fails++; $display("FAIL async_rst_state got %0d/%b/%0d want 0/0/0", cnt, ovf, drops); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_clear_vs_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/stereo_sample_fifo.md
# stereo_sample_fifo

Buffers stereo sample pairs from the I2S microphone receiver so the downstream DSP chain can consume them with a valid/ready handshake instead of a one-cycle strobe. It sits directly after the I2S receiver:
- the receiver's left/right sample outputs and new-sample pulse feed this block's write side;
- the filter/processing stage drains the read side at its own pace.

The block drops samples on overflow and records how many were lost.

## Interface
Parameters:
- DEPTH, 16: number of stereo pairs stored; must be a power of two, at least 2.
- WIDTH, 16: bits per channel sample, two's complement.

Ports:
- clock_in  input  1  system clock, 100 MHz.
- reset_n_in  input  1  asynchronous, active-low reset; one clock domain only.
- left_sample_in  input  WIDTH  signed left sample, valid when new_sample_in=1.
- right_sample_in  input  WIDTH  signed right sample, valid when new_sample_in=1.
- new_sample_in  input  1  single-cycle write strobe from the receiver.
- sample_ready_in  input  1  downstream can accept a pair this cycle.
- sample_valid_out  output  1  head pair is presented on the sample outputs.
- left_sample_out  output  WIDTH  head left sample; 0 when sample_valid_out=0.
- right_sample_out  output  WIDTH  head right sample; 0 when sample_valid_out=0.
- count_out  output  $clog2(DEPTH)+1  number of stored pairs, 0..DEPTH.
- overflow_out  output  1  sticky; set when any pair is dropped.
- drop_count_out  output  16  dropped pairs; saturates at 16'hFFFF.
- clear_overflow_in  input  1  synchronous clear of overflow_out and drop_count_out.

## Operation
- Storage is a DEPTH-entry array holding 2*WIDTH bits per entry, with the left sample in the upper half.
- Write pointer (wr_ptr) and read pointer (rd_ptr) are each $clog2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy is held in a registered counter, count.
- Push condition: new_sample_in=1. The push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
- Pop condition: sample_valid_out && sample_ready_in.
- sample_valid_out = (count != 0).
- The outputs are first-word-fall-through: entry mem[rd_ptr] is shown, gated to 0 when count==0.
- Count update:
  - push only: count+1;
  - pop only: count-1;
  - both: count unchanged, and both pointers advance.
- Drop: a push that is not accepted (count==DEPTH with no pop that cycle).
  - Stored data is untouched; the oldest samples are kept.
  - overflow_out is set to 1.
  - drop_count_out increments, saturating at 16'hFFFF.
- clear_overflow_in=1 sets overflow_out=0 and drop_count_out=0 on the next edge.
  - If a drop happens in the same cycle, the drop wins: overflow_out=1 and drop_count_out=1.
- A push while count==0 writes the entry; the entry appears on the outputs the following cycle. There is no bypass path.
- Pops while count==0 cannot occur, because valid is 0.
- sample_ready_in toggling while valid=0 has no effect.
- Input data is sampled only on the clock edge where new_sample_in=1.

## Timing
- Reset, asynchronous assert and any time mid-operation:
  - wr_ptr=0, rd_ptr=0, count=0;
  - sample_valid_out=0, left_sample_out=0, right_sample_out=0;
  - count_out=0, overflow_out=0, drop_count_out=0.
  - Stored contents are discarded logically; array contents need not be reset.
- Release of reset_n_in is synchronized by the top level; the first clock_in edge with reset_n_in=1 is a normal cycle.
- Write latency: new_sample_in high at edge N means sample_valid_out=1 and the data is visible after edge N, during cycle N+1.
- Pop: the handshake at edge M means the next entry (or valid=0) is visible after edge M.
- Throughput: one push and one pop per cycle.
- count_out, overflow_out and drop_count_out are registered and update at the same edge as the causing event.
- Receiver strobes arrive roughly every 1536 cycles, so normal operation never fills the block unless the consumer stalls.

## Test plan
- Reset, then push L=16'h1234, R=16'hFEDC with ready=0 -> after the next edge valid=1, outputs 1234/FEDC, count_out=1. Raise ready for one cycle -> valid=0, outputs 0, count_out=0.
- Push 16 pairs (L=i, R=-i for i=0..15) with ready=0 -> count_out=16. Drain with ready=1 -> pairs appear in order 0..15 on consecutive cycles; overflow_out stays 0.
- Fill to 16, then push 3 more with ready=0 -> overflow_out=1, drop_count_out=3. Drain yields 0..15, with none of the dropped pairs present.
- At count=16 assert new_sample_in and ready together -> push accepted, count_out stays 16, no drop. The new pair is last out after draining.
- Pointer wrap: run 40 pushes interleaved with pops, ready randomized but never full -> output sequence equals input sequence, and count_out tracks the pushes minus pops.
- With drop_count_out=5, assert clear_overflow_in on the same edge as a drop -> overflow_out=1, drop_count_out=1. Assert reset_n_in low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
